// File: rtl/sine_nco.sv
// sine_nco: numerically controlled oscillator built from a phase accumulator
// and a quarter-wave sine table with symmetry folding. Samples leave through
// a valid/ready handshake; a stall freezes the whole pipeline and the
// accumulator, so no sample is lost or repeated.
//
// Parameters
//   PHASE_W  phase accumulator width (must be >= ADDR_W+3)
//   ADDR_W   quarter-wave table address width (2^ADDR_W entries)
//   OUT_W    signed output sample width
//   MEM_FILE name of the quarter-wave table image; the table is built at
//            elaboration from its defining formula
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   en            request a new sample on each advancing cycle
//   freq_load     capture freq_word into the frequency register
//   freq_word     phase increment per sample
//   phase_offset  lookup-only phase offset (never accumulated)
//   phase_clr     zero the phase accumulator
//   out_ready     downstream accepts out_data
//   out_valid     out_data holds a sample
//   out_data      signed sine sample
module sine_nco #(
  parameter int    PHASE_W  = 24,
  parameter int    ADDR_W   = 8,
  parameter int    OUT_W    = 16,
  parameter string MEM_FILE = "sine_quarter.mem"
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    freq_load,
  input  logic [PHASE_W-1:0]      freq_word,
  input  logic [PHASE_W-1:0]      phase_offset,
  input  logic                    phase_clr,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data
);

  localparam int  DEPTH = 1 << ADDR_W;
  localparam real PI    = 3.14159265358979323846;
  localparam real AMP   = (2.0 ** (OUT_W - 1)) - 1.0;

  // Quarter-wave magnitudes, sampled at the middle of each index bin so the
  // folded halves mirror exactly without a duplicated zero or peak.
  logic [OUT_W-2:0] rom [DEPTH];

  // NOTE: the table is a ROM initialised at load time; it is never reset,
  // only the pipeline registers that carry state are.
  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      rom[k] = (OUT_W-1)'($rtoi(AMP * $sin(2.0 * PI * (k + 0.5) / (4.0 * DEPTH)) + 0.5));
    end
  end

  logic [PHASE_W-1:0] phase_acc;
  logic [PHASE_W-1:0] freq_reg;

  // Stage 0: lookup phase
  logic [PHASE_W-1:0] p_reg;
  logic               v0;
  // Stage 1: folded address
  logic [ADDR_W-1:0]  addr;
  logic               neg1;
  logic               v1;
  // Stage 2: table magnitude
  logic [OUT_W-2:0]   mag;
  logic               neg2;
  logic               v2;

  logic               adv;
  logic [1:0]         quad;
  logic [ADDR_W-1:0]  idx;
  logic [OUT_W-1:0]   mag_ext;
  logic               unused_low;

  // The pipeline moves only when the output slot is empty or being drained.
  assign adv = !out_valid || out_ready;

  // Top two bits select the quadrant; odd quadrants read the table backwards,
  // the lower half-cycle negates. Bits below the index are truncated.
  assign quad       = p_reg[PHASE_W-1 -: 2];
  assign idx        = p_reg[PHASE_W-3 -: ADDR_W];
  assign unused_low = ^p_reg[PHASE_W-ADDR_W-3:0];
  assign mag_ext    = {1'b0, mag};

  // NOTE: every register here uses non-blocking assignment so all stages
  // sample the previous cycle's values and the pipeline shifts in lockstep.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_acc <= '0;
      freq_reg  <= '0;
      p_reg     <= '0;
      v0        <= 1'b0;
      addr      <= '0;
      neg1      <= 1'b0;
      v1        <= 1'b0;
      mag       <= '0;
      neg2      <= 1'b0;
      v2        <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      // The frequency register is independent of the handshake; a new value
      // is used by the next accumulator update.
      if (freq_load) begin
        freq_reg <= freq_word;
      end

      // Clear wins over the increment; a lookup in the same cycle still
      // sees the old accumulator through p_reg below.
      if (phase_clr) begin
        phase_acc <= '0;
      end else if (adv && en) begin
        phase_acc <= phase_acc + freq_reg;
      end

      if (adv) begin
        v0 <= en;
        if (en) begin
          p_reg <= phase_acc + phase_offset;
        end

        addr <= quad[0] ? ~idx : idx;
        neg1 <= quad[1];
        v1   <= v0;

        mag  <= rom[addr];
        neg2 <= neg1;
        v2   <= v1;

        // The magnitude is at most 2^(OUT_W-1)-1, so negation cannot overflow.
        out_data  <= neg2 ? -mag_ext : mag_ext;
        out_valid <= v2;
      end
    end
  end

endmodule
